snake_score_ctrl: RTL

Score sequencer for the snake game. It accumulates a 4-digit packed-BCD score from food-eaten events using a digit-serial BCD adder, tracks the session high score, and drives the score word consumed by snake_scoreboard. After game over it alternates the scoreboard between the final score and the high score.

---
 rtl/snake_score_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/snake_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_score_ctrl
// Purpose  : Snake game score sequencer. Accumulates a 4-digit packed-BCD
//            score through a digit-serial BCD adder, keeps the session high
//            score and alternates final/high score on the scoreboard after
//            game over.
// Revision : 1.0 - initial release
// ============================================================================
module snake_score_ctrl #(
  parameter int SCORE_WIDTH = 16,
  parameter int DISP_TICKS  = 25000000,
  parameter int TIMER_WIDTH = 25
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_NewGame,
  input  logic                   i_Eat,
  input  logic [3:0]             i_Points,
  input  logic                   i_GameOver,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic                   o_ShowHigh,
  output logic                   o_NewHigh,
  output logic                   o_Busy,
  output logic                   o_Drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    ADD  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [SCORE_WIDTH-1:0] SAT_SCORE = {4{4'h9}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(DISP_TICKS - 1);

  state_t                   state;
  logic [SCORE_WIDTH-1:0]   score;
  logic [SCORE_WIDTH-1:0]   high;
  logic [SCORE_WIDTH-1:0]   work;
  logic [3:0]               addend;
  logic [1:0]               idx;
  logic                     carry;
  logic                     pend_eat;
  logic [3:0]               pend_pts;
  logic                     pend_go;
  logic [TIMER_WIDTH-1:0]   timer;
  logic                     show_high;
  logic                     new_high;
  logic                     drop;

  logic [3:0]               pts_clamped;
  logic [3:0]               cur_digit;
  logic [4:0]               digit_sum;
  logic [4:0]               digit_adj;
  logic                     digit_carry;
  logic [3:0]               digit_out;
  logic [SCORE_WIDTH-1:0]   work_next;
  logic [SCORE_WIDTH-1:0]   commit_val;
  logic                     pend_eat_n;
  logic [3:0]               pend_pts_n;
  logic                     pend_go_n;
  logic                     eat_lost;

  assign pts_clamped = (i_Points > 4'd9) ? 4'd9 : i_Points;

  // One BCD digit of the working copy per cycle; addend only enters digit 0.
  assign cur_digit   = work[{idx, 2'b00} +: 4];
  assign digit_sum   = {1'b0, cur_digit} + {1'b0, (idx == 2'd0) ? addend : 4'd0} + {4'd0, carry};
  assign digit_adj   = digit_sum - 5'd10;
  assign digit_carry = (digit_sum > 5'd9);
  assign digit_out   = digit_carry ? digit_adj[3:0] : digit_sum[3:0];

  // Working copy with the current digit replaced; carry out of digit 3 saturates.
  always_comb begin
    work_next = work;
    work_next[{idx, 2'b00} +: 4] = digit_out;
    commit_val = digit_carry ? SAT_SCORE : work_next;
  end

  // Fold this cycle's events (already lost to i_NewGame if asserted) into the pending flags.
  always_comb begin
    pend_go_n  = pend_go | i_GameOver;
    pend_eat_n = pend_eat;
    pend_pts_n = pend_pts;
    eat_lost   = 1'b0;
    if (i_Eat && !i_GameOver) begin
      if (pend_eat) begin
        eat_lost = 1'b1;
      end else begin
        pend_eat_n = 1'b1;
        pend_pts_n = pts_clamped;
      end
    end
  end

  // Main sequencer: play control, serial add, commit and game-over display.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      score     <= '0;
      high      <= '0;
      work      <= '0;
      addend    <= 4'd0;
      idx       <= 2'd0;
      carry     <= 1'b0;
      pend_eat  <= 1'b0;
      pend_pts  <= 4'd0;
      pend_go   <= 1'b0;
      timer     <= '0;
      show_high <= 1'b0;
      new_high  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      new_high <= 1'b0;
      drop     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_NewGame) begin
            score <= '0;
            state <= PLAY;
          end
        end
        PLAY: begin
          if (i_NewGame) begin
            score <= '0;
          end else if (i_GameOver) begin
            state     <= OVER;
            timer     <= '0;
            show_high <= 1'b0;
            if (score > high) begin
              high     <= score;
              new_high <= 1'b1;
            end
          end else if (i_Eat) begin
            work   <= score;
            addend <= pts_clamped;
            idx    <= 2'd0;
            carry  <= 1'b0;
            state  <= ADD;
          end
        end
        ADD: begin
          if (i_NewGame) begin
            score    <= '0;
            pend_eat <= 1'b0;
            pend_go  <= 1'b0;
            state    <= PLAY;
          end else begin
            work  <= work_next;
            carry <= digit_carry;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              score <= commit_val;
              if (pend_go_n) begin
                state     <= OVER;
                timer     <= '0;
                show_high <= 1'b0;
                drop      <= pend_eat_n;
                pend_eat  <= 1'b0;
                pend_go   <= 1'b0;
                if (commit_val > high) begin
                  high     <= commit_val;
                  new_high <= 1'b1;
                end
              end else if (pend_eat_n) begin
                work     <= commit_val;
                addend   <= pend_pts_n;
                idx      <= 2'd0;
                carry    <= 1'b0;
                pend_eat <= 1'b0;
                drop     <= eat_lost;
              end else begin
                state    <= PLAY;
                pend_eat <= 1'b0;
                pend_go  <= 1'b0;
                drop     <= eat_lost;
              end
            end else begin
              pend_eat <= pend_eat_n;
              pend_pts <= pend_pts_n;
              pend_go  <= pend_go_n;
              drop     <= eat_lost;
            end
          end
        end
        OVER: begin
          if (i_NewGame) begin
            score     <= '0;
            show_high <= 1'b0;
            timer     <= '0;
            state     <= PLAY;
          end else if (timer == TIMER_LAST) begin
            timer     <= '0;
            show_high <= ~show_high;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Score    = show_high ? high : score;
  assign o_ShowHigh = show_high;
  assign o_NewHigh  = new_high;
  assign o_Busy     = (state == ADD);
  assign o_Drop     = drop;

endmodule
`default_nettype wire
